ldm_stm_seq: RTL and testbench

Multi-register transfer sequencer for the ARM-style core. It executes LDM/STM by walking a 16-bit register list, one register per memory handshake. For STM it drives the register-file read port; for LDM it drives the register-file write port (we3/wa3/wd3 side). It reports the updated base address for optional base writeback.

---
 rtl/ldm_stm_seq.sv | 149 ++++++++++++++
 tb/tb_ldm_stm_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_seq.sv
// LDM/STM multi-register transfer sequencer: walks a 16-bit register list, one register per memory beat.
// Optional macro PC_LOAD_EN lets R15 take part in the transfer; an LDM of R15 then loads the PC.
module ldm_stm_seq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic              incr,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [3:0]        rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              rf_we,
    output logic [3:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr
);

    typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;

    state_t            state, state_nxt;
    logic [15:0]       list_q, list_left, eff_list;
    logic              load_q;
    logic [3:0]        ra_q;
    logic [ADDR_W-1:0] addr_q, wb_q, span;
    logic [4:0]        cnt;
    logic              hs, last_beat;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

`ifdef PC_LOAD_EN
    assign eff_list = reg_list;
`else
    assign eff_list = {1'b0, reg_list[14:0]};
`endif

    assign cnt       = popcount16(eff_list);
    assign span      = ADDR_W'({cnt, 2'b00});
    assign hs        = (state == XFER) && mem_ready;
    assign list_left = list_q & ~(16'd1 << ra_q);
    assign last_beat = (list_left == 16'd0);

    assign rf_ra    = ra_q;
    assign mem_addr = addr_q;
    assign wb_addr  = wb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (cnt != 5'd0) ? XFER : FINISH;
            XFER:    if (hs && last_beat) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Writeback value is fixed at start so FINISH needs no arithmetic of its own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            list_q <= '0;
            load_q <= 1'b0;
            ra_q   <= '0;
            addr_q <= '0;
            wb_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        list_q <= eff_list;
                        load_q <= is_load;
                        ra_q   <= lowest_set(eff_list);
                        addr_q <= incr ? base_addr : base_addr - span;
                        wb_q   <= incr ? base_addr + span : base_addr - span;
                    end
                end
                XFER: begin
                    if (hs) begin
                        list_q <= list_left;
                        ra_q   <= lowest_set(list_left);
                        addr_q <= addr_q + ADDR_W'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FINISH);
        wb_valid  = (state == FINISH);
        mem_req   = (state == XFER);
        mem_we    = (state == XFER) && !load_q;
        mem_wdata = (state == XFER) ? rf_rd : '0;
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        pc_we     = 1'b0;
        pc_wd     = '0;
        if (hs && load_q) begin
`ifdef PC_LOAD_EN
            if (ra_q == 4'd15) begin
                pc_we = 1'b1;
                pc_wd = mem_rdata;
            end else begin
                rf_we = 1'b1;
                rf_wa = ra_q;
                rf_wd = mem_rdata;
            end
`else
            rf_we = 1'b1;
            rf_wa = ra_q;
            rf_wd = mem_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Expectations for the R15 test depend on whether PC_LOAD_EN is defined.
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_load, incr;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic        busy, done;
    logic [3:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_addr;

    logic [31:0] rf_model [16];
    int          checks = 0;
    int          errors = 0;

    assign rf_rd = rf_model[rf_ra];

    always #5 clk = ~clk;

    ldm_stm_seq #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .incr(incr),
        .reg_list(reg_list), .base_addr(base_addr), .busy(busy), .done(done),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pc_we(pc_we), .pc_wd(pc_wd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_addr(wb_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic ld, input logic inc,
                                 input logic [15:0] lst, input logic [31:0] base,
                                 input logic rdy, input logic [31:0] rdata);
        start     = st;
        is_load   = ld;
        incr      = inc;
        reg_list  = lst;
        base_addr = base;
        mem_ready = rdy;
        mem_rdata = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_model[i] = 32'h0;
        rf_model[0]  = 32'hA0;
        rf_model[1]  = 32'h11;
        rf_model[2]  = 32'h22;
        rf_model[4]  = 32'h44;
        rf_model[15] = 32'h1008;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
        #2;
        checkFlag("rst busy", busy, 1'b0);
        checkFlag("rst done", done, 1'b0);
        checkFlag("rst mem_req", mem_req, 1'b0);
        checkFlag("rst wb_valid", wb_valid, 1'b0);
        checkOutput("rst mem_addr", mem_addr, 32'h0);
        checkOutput("rst wb_addr", wb_addr, 32'h0);
        checkOutput("rst mem_wdata", mem_wdata, 32'h0);
        tick();
        reset = 1'b0;

        $display("[TB] test 1: STM IA 0x0016");
        tick(); applyStimulus(1'b1, 1'b0, 1'b1, 16'h0016, 32'h100, 1'b1, 32'h0);
        @(negedge clk); checkFlag("t1 c0 busy", busy, 1'b0);
        tick(); applyStimulus(1'b0, 1'b0, 1'b1, 16'h0016, 32'h100, 1'b1, 32'h0);
        @(negedge clk);
        checkFlag("t1 c1 mem_req", mem_req, 1'b1);
        checkFlag("t1 c1 mem_we", mem_we, 1'b1);
        checkFlag("t1 c1 busy", busy, 1'b1);
        checkOutput("t1 c1 addr", mem_addr, 32'h100);
        checkOutput("t1 c1 wdata", mem_wdata, 32'h11);
        checkFlag("t1 c1 rf_we", rf_we, 1'b0);
        tick(); @(negedge clk);
        checkOutput("t1 c2 addr", mem_addr, 32'h104);
        checkOutput("t1 c2 wdata", mem_wdata, 32'h22);
        tick(); @(negedge clk);
        checkOutput("t1 c3 addr", mem_addr, 32'h108);
        checkOutput("t1 c3 wdata", mem_wdata, 32'h44);
        tick(); @(negedge clk);
        checkFlag("t1 c4 done", done, 1'b1);
        checkFlag("t1 c4 wb_valid", wb_valid, 1'b1);
        checkFlag("t1 c4 mem_req", mem_req, 1'b0);
        checkOutput("t1 c4 wb_addr", wb_addr, 32'h10C);
        tick(); @(negedge clk);
        checkFlag("t1 c5 done", done, 1'b0);
        checkFlag("t1 c5 busy", busy, 1'b0);

        $display("[TB] test 2: LDM DB 0x00C0");
        tick(); applyStimulus(1'b1, 1'b1, 1'b0, 16'h00C0, 32'h200, 1'b1, 32'h0);
        tick(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h00C0, 32'h200, 1'b1, 32'hA);
        @(negedge clk);
        checkFlag("t2 c1 mem_we", mem_we, 1'b0);
        checkOutput("t2 c1 addr", mem_addr, 32'h1F8);
        checkFlag("t2 c1 rf_we", rf_we, 1'b1);
        checkOutput("t2 c1 rf_wa", 32'(rf_wa), 32'd6);
        checkOutput("t2 c1 rf_wd", rf_wd, 32'hA);
        tick(); mem_rdata = 32'hB;
        @(negedge clk);
        checkOutput("t2 c2 addr", mem_addr, 32'h1FC);
        checkOutput("t2 c2 rf_wa", 32'(rf_wa), 32'd7);
        checkOutput("t2 c2 rf_wd", rf_wd, 32'hB);
        tick(); @(negedge clk);
        checkFlag("t2 c3 done", done, 1'b1);
        checkFlag("t2 c3 rf_we", rf_we, 1'b0);
        checkOutput("t2 c3 wb_addr", wb_addr, 32'h1F8);

        $display("[TB] test 3: LDM IA with stall and ignored start");
        tick(); applyStimulus(1'b1, 1'b1, 1'b1, 16'h0009, 32'h400, 1'b1, 32'h0);
        tick(); applyStimulus(1'b0, 1'b1, 1'b1, 16'h0009, 32'h400, 1'b1, 32'h1234);
        @(negedge clk);
        checkOutput("t3 c1 rf_wa", 32'(rf_wa), 32'd0);
        checkOutput("t3 c1 rf_wd", rf_wd, 32'h1234);
        tick(); applyStimulus(1'b1, 1'b0, 1'b0, 16'h00FF, 32'h0, 1'b0, 32'hDEAD);
        @(negedge clk);
        checkFlag("t3 c2 mem_req", mem_req, 1'b1);
        checkOutput("t3 c2 addr", mem_addr, 32'h404);
        checkFlag("t3 c2 rf_we", rf_we, 1'b0);
        tick(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'hDEAD);
        @(negedge clk);
        checkFlag("t3 c3 mem_req", mem_req, 1'b1);
        checkFlag("t3 c3 mem_we", mem_we, 1'b0);
        checkFlag("t3 c3 rf_we", rf_we, 1'b0);
        tick(); @(negedge clk);
        checkOutput("t3 c4 addr", mem_addr, 32'h404);
        checkFlag("t3 c4 done", done, 1'b0);
        tick(); mem_ready = 1'b1; mem_rdata = 32'h5678;
        @(negedge clk);
        checkFlag("t3 c5 rf_we", rf_we, 1'b1);
        checkOutput("t3 c5 rf_wa", 32'(rf_wa), 32'd3);
        checkOutput("t3 c5 rf_wd", rf_wd, 32'h5678);
        tick(); @(negedge clk);
        checkFlag("t3 c6 done", done, 1'b1);
        checkOutput("t3 c6 wb_addr", wb_addr, 32'h408);
        tick(); @(negedge clk);
        checkFlag("t3 c7 busy", busy, 1'b0);

        $display("[TB] test 4: empty list");
        tick(); applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 32'h300, 1'b1, 32'h0);
        tick(); applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 32'h300, 1'b1, 32'h0);
        @(negedge clk);
        checkFlag("t4 c1 done", done, 1'b1);
        checkFlag("t4 c1 wb_valid", wb_valid, 1'b1);
        checkFlag("t4 c1 mem_req", mem_req, 1'b0);
        checkOutput("t4 c1 wb_addr", wb_addr, 32'h300);

        $display("[TB] test 5: STM IA address wrap");
        tick(); applyStimulus(1'b1, 1'b0, 1'b1, 16'h0003, 32'hFFFF_FFFC, 1'b1, 32'h0);
        tick(); applyStimulus(1'b0, 1'b0, 1'b1, 16'h0003, 32'hFFFF_FFFC, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("t5 c1 addr", mem_addr, 32'hFFFF_FFFC);
        checkOutput("t5 c1 wdata", mem_wdata, 32'hA0);
        tick(); @(negedge clk);
        checkOutput("t5 c2 addr", mem_addr, 32'h0);
        checkOutput("t5 c2 wdata", mem_wdata, 32'h11);
        tick(); @(negedge clk);
        checkFlag("t5 c3 done", done, 1'b1);
        checkOutput("t5 c3 wb_addr", wb_addr, 32'h4);

        $display("[TB] test 6: LDM with R15, reset mid-transfer, rerun");
        tick(); applyStimulus(1'b1, 1'b1, 1'b1, 16'h8001, 32'h40, 1'b1, 32'h0);
        tick(); applyStimulus(1'b0, 1'b1, 1'b1, 16'h8001, 32'h40, 1'b1, 32'hAAAA);
        @(negedge clk);
        checkFlag("t6a c1 rf_we", rf_we, 1'b1);
        checkOutput("t6a c1 rf_wd", rf_wd, 32'hAAAA);
        reset = 1'b1;
        #1;
        checkFlag("t6 rst busy", busy, 1'b0);
        checkFlag("t6 rst mem_req", mem_req, 1'b0);
        checkFlag("t6 rst rf_we", rf_we, 1'b0);
        checkFlag("t6 rst done", done, 1'b0);
        checkFlag("t6 rst wb_valid", wb_valid, 1'b0);
        checkOutput("t6 rst mem_addr", mem_addr, 32'h0);
        checkOutput("t6 rst wb_addr", wb_addr, 32'h0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
        tick(); applyStimulus(1'b1, 1'b1, 1'b1, 16'h8001, 32'h40, 1'b1, 32'h0);
        tick(); applyStimulus(1'b0, 1'b1, 1'b1, 16'h8001, 32'h40, 1'b1, 32'h77);
        @(negedge clk);
        checkOutput("t6 c1 addr", mem_addr, 32'h40);
        checkFlag("t6 c1 rf_we", rf_we, 1'b1);
        checkOutput("t6 c1 rf_wa", 32'(rf_wa), 32'd0);
        checkFlag("t6 c1 pc_we", pc_we, 1'b0);
`ifdef PC_LOAD_EN
        tick(); mem_rdata = 32'h99;
        @(negedge clk);
        checkOutput("t6 c2 addr", mem_addr, 32'h44);
        checkFlag("t6 c2 pc_we", pc_we, 1'b1);
        checkOutput("t6 c2 pc_wd", pc_wd, 32'h99);
        checkFlag("t6 c2 rf_we", rf_we, 1'b0);
        tick(); @(negedge clk);
        checkFlag("t6 c3 done", done, 1'b1);
        checkOutput("t6 c3 wb_addr", wb_addr, 32'h48);
`else
        tick(); @(negedge clk);
        checkFlag("t6 c2 done", done, 1'b1);
        checkFlag("t6 c2 mem_req", mem_req, 1'b0);
        checkFlag("t6 c2 pc_we", pc_we, 1'b0);
        checkOutput("t6 c2 pc_wd", pc_wd, 32'h0);
        checkOutput("t6 c2 wb_addr", wb_addr, 32'h44);
`endif
        tick(); @(negedge clk);
        checkFlag("t6 end busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
